// File: rtl/sync_debounce.sv
// Multi-channel CDC synchronizer with per-channel glitch filter.
// A change is accepted after FILTER stable cycles; rise/fall pulse once.
module sync_debounce #(
  parameter int               WIDTH     = 4,
  parameter int               FLOPS     = 2,
  parameter int               FILTER    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [CW-1:0] CMAX = CW'(FILTER - 1);

  logic [FLOPS-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0][CW-1:0]    r_cnt;
  logic [WIDTH-1:0]            r_level;
  logic [WIDTH-1:0]            r_rise;
  logic [WIDTH-1:0]            r_fall;
  logic [WIDTH-1:0]            w_sync;
  logic [WIDTH-1:0]            w_acc;

  assign w_sync = r_sync[FLOPS-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= {FLOPS{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[FLOPS-2:0], data};
    end
  end

  // Accept only when the mismatch has survived FILTER consecutive edges.
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_acc[i] = (w_sync[i] != r_level[i]) && (r_cnt[i] == CMAX);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt   <= '0;
      r_level <= RESET_VAL;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_sync[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (w_acc[i]) begin
          r_cnt[i]   <= '0;
          r_level[i] <= w_sync[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_acc & w_sync;
      r_fall <= w_acc & ~w_sync;
    end
  end

  assign sync  = w_sync;
  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: FLOPS=2, FILTER=4, RESET_VAL=4'b0101.
// Inputs change #1 after posedge; outputs checked there or at negedge.
module tb_sync_debounce;

  logic       clk;
  logic       rstn;
  logic [3:0] data;
  logic [3:0] sync;
  logic [3:0] level;
  logic [3:0] rise;
  logic [3:0] fall;

  int n_tot;
  int n_pass;
  int rc [4];
  int fc [4];
  int both;
  int s2;

  sync_debounce #(
    .WIDTH    (4),
    .FLOPS    (2),
    .FILTER   (4),
    .RESET_VAL(4'b0101)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .data (data),
    .sync (sync),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      rc[i] += int'(rise[i]);
      fc[i] += int'(fall[i]);
    end
    if ((rise & fall) != 4'b0) both++;
    if (sync[2]) s2++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int pulses();
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += rc[i] + fc[i];
    return s;
  endfunction

  initial begin
    int  r0;
    int  s0;
    int  p0;
    bit  pat [8];
    n_tot  = 0;
    n_pass = 0;
    both   = 0;
    s2     = 0;
    for (int i = 0; i < 4; i++) begin
      rc[i] = 0;
      fc[i] = 0;
    end
    pat  = '{1, 1, 1, 0, 1, 1, 1, 1};
    rstn = 1'b0;
    data = 4'b0000;

    // reset state
    tick(2);
    check("rst_level", 32'(level), 32'h5);
    check("rst_sync", 32'(sync), 32'h5);
    check("rst_rise", 32'(rise), 32'h0);
    check("rst_fall", 32'(fall), 32'h0);

    // release with data != RESET_VAL
    rstn = 1'b1;
    tick(5);
    check("rel_e5_level", 32'(level), 32'h5);
    check("rel_e5_fall", 32'(fall), 32'h0);
    tick();
    check("rel_e6_fall", 32'(fall), 32'h5);
    check("rel_e6_level", 32'(level), 32'h0);
    tick();
    check("rel_e7_fall", 32'(fall), 32'h0);

    // clean step on channel 1
    data = 4'b0010;
    tick();
    check("step_e1_sync", 32'(sync), 32'h0);
    tick();
    check("step_e2_sync", 32'(sync), 32'h2);
    tick(3);
    check("step_e5_level", 32'(level), 32'h0);
    tick();
    check("step_e6_level", 32'(level), 32'h2);
    check("step_e6_rise", 32'(rise), 32'h2);
    check("step_e6_fall", 32'(fall), 32'h0);
    tick();
    check("step_e7_rise", 32'(rise), 32'h0);

    // 3-cycle glitch on channel 2
    r0 = rc[2];
    s0 = s2;
    data = 4'b0110;
    tick(3);
    data = 4'b0010;
    tick(10);
    check("glitch3_sync_len", 32'(s2 - s0), 32'd3);
    check("glitch3_level", 32'(level), 32'h2);
    check("glitch3_rise", 32'(rc[2] - r0), 32'd0);

    // 4-cycle pulse on channel 2 is accepted
    r0 = rc[2];
    p0 = fc[2];
    data = 4'b0110;
    tick(4);
    data = 4'b0010;
    tick();
    check("g4_e5_level", 32'(level), 32'h2);
    tick();
    check("g4_e6_level", 32'(level), 32'h6);
    check("g4_e6_rise", 32'(rise), 32'h4);
    tick(3);
    check("g4_e9_level", 32'(level), 32'h6);
    tick();
    check("g4_e10_level", 32'(level), 32'h2);
    check("g4_e10_fall", 32'(fall), 32'h4);
    tick(3);
    check("g4_rise_cnt", 32'(rc[2] - r0), 32'd1);
    check("g4_fall_cnt", 32'(fc[2] - p0), 32'd1);

    // chatter on channel 0: counter must restart after the 0
    r0 = rc[0];
    for (int i = 0; i < 8; i++) begin
      data[0] = pat[i];
      tick();
    end
    check("chat_e8_level", 32'(level), 32'h2);
    tick();
    check("chat_e9_level", 32'(level), 32'h2);
    check("chat_e9_rise", 32'(rc[0] - r0), 32'd0);
    tick();
    check("chat_e10_level", 32'(level), 32'h3);
    check("chat_e10_rise", 32'(rise), 32'h1);

    // simultaneous accepts on all channels
    data = 4'b0000;
    tick(8);
    check("sim_base_level", 32'(level), 32'h0);
    data = 4'b1111;
    tick(6);
    check("sim_rise", 32'(rise), 32'hf);
    check("sim_rise_level", 32'(level), 32'hf);
    tick();
    check("sim_rise_end", 32'(rise), 32'h0);
    data = 4'b0000;
    tick(6);
    check("sim_fall", 32'(fall), 32'hf);
    check("sim_fall_level", 32'(level), 32'h0);
    tick();
    check("sim_fall_end", 32'(fall), 32'h0);

    // reset while channel 1 is at cnt=2
    data = 4'b0010;
    tick(4);
    p0 = pulses();
    rstn = 1'b0;
    #1;
    check("mid_rst_level", 32'(level), 32'h5);
    check("mid_rst_sync", 32'(sync), 32'h5);
    tick(2);
    check("mid_rst_pulses", 32'(pulses() - p0), 32'd0);
    data = 4'b0111;
    rstn = 1'b1;
    tick(5);
    check("mid_rel_e5_level", 32'(level), 32'h5);
    check("mid_rel_e5_rise", 32'(rise), 32'h0);
    tick();
    check("mid_rel_e6_level", 32'(level), 32'h7);
    check("mid_rel_e6_rise", 32'(rise), 32'h2);
    check("mid_rel_e6_fall", 32'(fall), 32'h0);
    tick(2);

    check("rise_and_fall", 32'(both), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
- Multi-channel clock-domain-crossing synchronizer with a per-channel glitch filter and edge detection.
- Each channel passes through a FLOPS-deep synchronizer chain. A debounce stage follows, and a level change is accepted only after it stays stable for FILTER consecutive clk cycles.
- Each accepted change produces one-cycle rise/fall pulses.
- Used for asynchronous pins: buttons, jack-detect, codec status, mute and similar control lines.

Parameters:
- WIDTH, 4: number of independent channels (>=1).
- FLOPS, 2: synchronizer stages per channel (>=2).
- FILTER, 4: consecutive stable cycles required to accept a change (>=1; 1 = no filtering beyond one extra register).
- RESET_VAL, {WIDTH{1'b0}}: per-channel reset value of the synchronizer stages and of level.

Ports:
- clk  input  1  system clock.
- rstn  input  1  reset, asynchronous, active-low.
- data  input  WIDTH  asynchronous inputs, one bit per channel.
- sync  output  WIDTH  raw synchronizer outputs (last stage of each chain).
- level  output  WIDTH  debounced level per channel.
- rise  output  WIDTH  one-cycle pulse when level changes 0->1.
- fall  output  WIDTH  one-cycle pulse when level changes 1->0.

Behaviour:
- Reset (rstn low, asynchronous):
  - all synchronizer stages of channel i = RESET_VAL[i];
  - level[i] = RESET_VAL[i];
  - debounce counters = 0;
  - rise = fall = 0.
- Synchronizer: on each clk edge, stage0[i] <= data[i] and stage[k][i] <= stage[k-1][i]. sync[i] = stage[FLOPS-1][i]. Latency is FLOPS edges.
- Debounce counter: one per channel, width clog2(FILTER) (minimum 1 bit). On each edge:
  - If sync[i] == level[i]: cnt <= 0.
  - If sync[i] != level[i] and cnt < FILTER-1: cnt <= cnt+1.
  - If sync[i] != level[i] and cnt == FILTER-1: level[i] <= sync[i], cnt <= 0 (accept).
- Rise/fall:
  - rise[i] <= accept && sync[i]; fall[i] <= accept && !sync[i]. Both are registered on the same edge that updates level.
  - rise/fall are high for exactly one cycle, the first cycle in which the new level is visible.
  - rise and fall are never high together on one channel.
- Total latency from the first edge sampling new data to level/rise/fall = FLOPS + FILTER edges.
- Glitch rejection: any mismatch run shorter than FILTER cycles at sync clears the counter and leaves level unchanged, with no pulse.
- Reversal: if sync returns to level on the same edge cnt would otherwise increment, the counter clears. The filter restarts from 0 on the next mismatch; there is no partial credit.
- Channels are fully independent. Simultaneous accepts on several channels each produce their own pulse in the same cycle.
- Reset mid-operation: pending counts are discarded immediately and no pulse is generated.
- Data differing from RESET_VAL when reset deasserts: treated as a normal change. Level is accepted and pulsed FLOPS+FILTER edges later.
- No combinational path from data to any output. All outputs are registered.

Test Plan:
- Reset with WIDTH=4, RESET_VAL=4'b0101, data=4'b0000: during and after reset, level=4'b0101, rise=fall=0. Releasing rstn gives fall[0] and fall[2] pulsing once at edge 6 (FLOPS=2, FILTER=4); level becomes 4'b0000.
- Clean step, FLOPS=2, FILTER=4: data[1] 0->1 before edge 1 gives sync[1]=1 after edge 2, level[1]=1 and rise[1]=1 after edge 6, rise[1]=0 after edge 7; no other channel changes.
- Glitch: data[2] high for exactly 3 cycles gives sync[2] pulsing for 3 cycles, level[2] staying 0 and no rise. Repeating with 4 cycles gives level[2]=1 with one rise[2] pulse, then level returning to 0 with one fall[2] pulse 4 cycles after sync falls.
- Chatter: data[0] toggles 1,1,1,0,1,1,1,1, one value per cycle. The counter restarts after the 0, and rise[0] occurs 4 edges after the second run appears at sync, not earlier.
- Simultaneous: data=4'b1111 from all-zero gives rise=4'b1111 for exactly one cycle. Then data=4'b0000 gives fall=4'b1111; rise&fall is 0 at all times.
- Reset mid-count: assert rstn low while a channel is at cnt=2 with sync!=level. Level returns to RESET_VAL immediately and no pulse occurs; after release, counting restarts from 0.
